// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store bridge between a single-cycle datapath and a multi-cycle req/ack data bus.
//   An aligned cpu_req is captured into registered bus_* outputs and held until the slave
//   acknowledges or the wait exceeds TIMEOUT cycles. The datapath is stalled meanwhile,
//   and load data comes back right-justified by the byte offset (zero-filled, unsigned).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cpu_req             datapath access request (level, held while stall=1)
//   cpu_addr            byte address
//   cpu_wea, cpu_wdata  lane-aligned store enables / data (wea==0 means load)
//   cpu_len             000 lbu, 001 lb, 010 lhu, 011 lh, 100 word
//   cpu_rdata           right-justified load data, valid with done
//   stall               hold the datapath this cycle
//   done, err           one-cycle completion pulse, error flag alongside it
//   misalign            combinational: request with illegal alignment/length
//   bus_req/we/addr/wea/wdata  registered bus request side
//   bus_ack, bus_err, bus_rdata  bus response side (err/rdata valid with ack)

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wea,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_len,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wea,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  offset;
  logic        aligned;

  // Length codes outside the table are folded into "misaligned" so they never reach the bus.
  function automatic logic legal_access(input logic [2:0] len, input logic [1:0] a);
    case (len)
      3'b000, 3'b001: return 1'b1;
      3'b010, 3'b011: return a != 2'b11;
      3'b100:         return a == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] shift_rdata(input logic [31:0] w, input logic [1:0] o);
    return w >> {o, 3'b000};
  endfunction

  always_comb begin
    aligned  = legal_access(cpu_len, cpu_addr[1:0]);
    misalign = cpu_req & ~aligned;
    // The capture cycle in IDLE already stalls so the PC does not move past the access.
    stall    = (state == REQ) | ((state == IDLE) & cpu_req & aligned);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      offset    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wea   <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= |cpu_wea;
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_wea   <= cpu_wea;
            bus_wdata <= cpu_wdata;
            offset    <= cpu_addr[1:0];
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) cpu_rdata <= shift_rdata(bus_rdata, offset);
            err     <= bus_err;
            done    <= 1'b1;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus_req   <= 1'b0;
            cpu_rdata <= '0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          // cpu_req still high here belongs to the instruction being retired.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wea;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_len;
  logic [31:0] cpu_rdata;
  logic        stall, done, err, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wea;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] hold_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wea(cpu_wea),
    .cpu_wdata(cpu_wdata), .cpu_len(cpu_len),
    .cpu_rdata(cpu_rdata), .stall(stall), .done(done), .err(err), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wea(bus_wea),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  // One access from request to done. Called at posedge+1; returns at posedge+1 after done.
  // ack_at = REQ cycle on which the slave acks (0 = never, expect timeout).
  task automatic access(input string name, input logic [31:0] a, input logic [3:0] wea,
                        input logic [31:0] wd, input logic [2:0] len, input int ack_at,
                        input logic [31:0] word, input logic berr);
    exp_t e;
    int   cyc = 0;
    int   reqc = 0;
    bit   got = 0;
    int   exp_lat;
    if (ack_at == 0) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else begin
      e.rdata = (wea != 0) ? hold_rdata : (word >> (8 * int'(a[1:0])));
      e.err   = berr;
    end
    hold_rdata = e.rdata;
    sb.push_back(e);
    exp_lat = (ack_at == 0) ? TO + 2 : ack_at + 2;
    cpu_addr = a; cpu_wea = wea; cpu_wdata = wd; cpu_len = len; cpu_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        exp_t g;
        got = 1;
        checks++;
        if (sb.size() == 0) $display("FAIL %s scoreboard: done with empty queue", name);
        else begin
          g = sb.pop_front();
          if (cpu_rdata !== g.rdata)
            $display("FAIL %s rdata: got %h expected %h", name, cpu_rdata, g.rdata);
          else if (err !== g.err)
            $display("FAIL %s err: got %b expected %b", name, err, g.err);
          else passed++;
        end
        checks++;
        if (cyc !== exp_lat || stall !== 1'b0 || bus_req !== 1'b0)
          $display("FAIL %s done_cycle: cycle %0d stall %b bus_req %b expected cycle %0d stall 0 bus_req 0",
                   name, cyc, stall, bus_req, exp_lat);
        else passed++;
        checks++;
        if (reqc !== ((ack_at == 0) ? TO : ack_at))
          $display("FAIL %s req_cycles: got %0d expected %0d", name, reqc,
                   (ack_at == 0) ? TO : ack_at);
        else passed++;
      end else begin
        checks++;
        if (stall !== 1'b1) $display("FAIL %s stall: cycle %0d got %b expected 1", name, cyc, stall);
        else passed++;
        if (bus_req) begin
          reqc++;
          checks++;
          if (bus_addr !== {a[31:2], 2'b00} || bus_we !== (wea != 0) ||
              bus_wea !== wea || (wea != 0 && bus_wdata !== wd))
            $display("FAIL %s bus_fields: addr %h we %b wea %b wdata %h expected addr %h we %b wea %b wdata %h",
                     name, bus_addr, bus_we, bus_wea, bus_wdata, {a[31:2], 2'b00}, (wea != 0), wea, wd);
          else passed++;
          if (reqc == ack_at) begin
            bus_ack = 1'b1; bus_err = berr; bus_rdata = word;
          end
        end
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s completion: no done within 40 cycles, expected done", name);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 0; cpu_addr = 0; cpu_wea = 0; cpu_wdata = 0; cpu_len = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    hold_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 0 || bus_we !== 0 || done !== 0 || err !== 0 || stall !== 0)
      $display("FAIL reset_ctrl: req %b we %b done %b err %b stall %b expected all 0",
               bus_req, bus_we, done, err, stall);
    else passed++;
    checks++;
    if (bus_addr !== 0 || bus_wea !== 0 || bus_wdata !== 0 || cpu_rdata !== 0)
      $display("FAIL reset_data: addr %h wea %b wdata %h rdata %h expected 0",
               bus_addr, bus_wea, bus_wdata, cpu_rdata);
    else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_loads();
    access("word_load", 32'h100, 4'b0000, 32'h0, 3'b100, 2, 32'h1122_3344, 1'b0);
    access("byte_load", 32'h103, 4'b0000, 32'h0, 3'b000, 1, 32'hAABB_CCDD, 1'b0);
    access("half_load", 32'h102, 4'b0000, 32'h0, 3'b011, 3, 32'hAABB_CCDD, 1'b0);
    access("byte1_load", 32'h201, 4'b0000, 32'h0, 3'b001, 1, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_store();
    access("store_half", 32'h202, 4'b1100, 32'h5566_0000, 3'b010, 3, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    access("timeout", 32'h300, 4'b0000, 32'h0, 3'b100, 0, 32'h0, 1'b0);
  endtask

  task automatic test_bus_err();
    access("bus_err", 32'h304, 4'b0000, 32'h0, 3'b100, 1, 32'hCAFE_F00D, 1'b1);
    // ack on the last counter cycle must still win over the timeout
    access("ack_at_limit", 32'h308, 4'b0000, 32'h0, 3'b100, TO, 32'h0BAD_CAFE, 1'b0);
  endtask

  task automatic test_misalign();
    logic [31:0] addrs[3] = '{32'h102, 32'h103, 32'h100};
    logic [2:0]  lens[3]  = '{3'b100, 3'b010, 3'b101};
    for (int i = 0; i < 3; i++) begin
      cpu_addr = addrs[i]; cpu_len = lens[i]; cpu_wea = 0; cpu_req = 1'b1;
      #1;
      checks++;
      if (misalign !== 1'b1 || stall !== 1'b0)
        $display("FAIL misalign_%0d: misalign %b stall %b expected 1 0", i, misalign, stall);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (bus_req !== 1'b0 || done !== 1'b0)
        $display("FAIL misalign_nobus_%0d: bus_req %b done %b expected 0 0", i, bus_req, done);
      else passed++;
      cpu_req = 1'b0;
    end
    cpu_addr = 32'h103; cpu_len = 3'b001; cpu_req = 1'b0;
    #1;
    checks++;
    if (misalign !== 1'b0) $display("FAIL misalign_idle: got %b expected 0", misalign);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ack_outside();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    checks++;
    if (done !== 1'b0 || cpu_rdata !== hold_rdata)
      $display("FAIL stray_ack: done %b rdata %h expected 0 %h", done, cpu_rdata, hold_rdata);
    else passed++;
  endtask

  task automatic test_reset_mid();
    cpu_addr = 32'h400; cpu_wea = 0; cpu_len = 3'b100; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) $display("FAIL mid_req: bus_req %b expected 1", bus_req);
    else passed++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || cpu_rdata !== 0)
      $display("FAIL mid_reset: bus_req %b rdata %h expected 0 0", bus_req, cpu_rdata);
    else passed++;
    cpu_req = 1'b0;
    hold_rdata = 0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    access("after_reset", 32'h404, 4'b0000, 32'h0, 3'b100, 0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    access("b2b_a", 32'h500, 4'b0000, 32'h0, 3'b100, 1, 32'h0102_0304, 1'b0);
    access("b2b_b", 32'h502, 4'b0011, 32'h0000_BEEF, 3'b010, 2, 32'h0, 1'b0);
    access("b2b_c", 32'h501, 4'b0000, 32'h0, 3'b000, 1, 32'h99AA_BBCC, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_timeout();
    test_bus_err();
    test_misalign();
    test_ack_outside();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
